// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port among N_REQ writeback requesters.
// It uses a round-robin grant, registered write strobes, R15 diversion to the PC port and a busy scoreboard.
module rf_write_arbiter #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    output logic [15:0]               busy,
    output logic                      WE3,
    output logic [ADDR_W-1:0]         A3,
    output logic [DATA_W-1:0]         WD3,
    output logic                      pc_we,
    output logic [DATA_W-1:0]         pc_wd
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(15);

    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [DATA_W-1:0] data_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [PTR_W-1:0]  ptr_reg;
    logic [PTR_W-1:0]  ptr_next;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_found;
    logic [PTR_W:0]    scan_idx;
    logic [N_REQ-1:0]  grant;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_is_pc;

    // Rotating priority search starting at ptr; reset masks every grant.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, ptr_reg} + (PTR_W+1)'(k);
            if (scan_idx >= (PTR_W+1)'(N_REQ)) begin
                scan_idx = scan_idx - (PTR_W+1)'(N_REQ);
            end
            if (!grant_found && req_valid[scan_idx[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[PTR_W-1:0];
            end
        end
        if (grant_found && !rst) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign xfer      = grant_found && !rst;
    assign sel_addr  = addr_arr[grant_idx];
    assign sel_data  = data_arr[grant_idx];
    assign sel_is_pc = (sel_addr == PC_ADDR);

    always_comb begin
        ptr_next = ptr_reg;
        if (xfer) begin
            if (grant_idx == PTR_W'(N_REQ - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_idx + PTR_W'(1);
            end
        end
    end

    logic              we3_reg;
    logic [ADDR_W-1:0] a3_reg;
    logic [DATA_W-1:0] wd3_reg;
    logic              pc_we_reg;
    logic [DATA_W-1:0] pc_wd_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg   <= '0;
            we3_reg   <= 1'b0;
            a3_reg    <= '0;
            wd3_reg   <= '0;
            pc_we_reg <= 1'b0;
            pc_wd_reg <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            we3_reg   <= xfer && !sel_is_pc;
            pc_we_reg <= xfer && sel_is_pc;
            if (xfer && !sel_is_pc) begin
                a3_reg  <= sel_addr;
                wd3_reg <= sel_data;
            end
            if (xfer && sel_is_pc) begin
                pc_wd_reg <= sel_data;
            end
        end
    end

    // Scoreboard: a same-cycle reserve beats the clear, since it marks a newer write.
    logic [15:0] busy_reg;
    logic [15:0] busy_next;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit       = rsv_valid && (rsv_addr == ADDR_W'(gi));
            assign clr_bit       = xfer && (sel_addr == ADDR_W'(gi));
            assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= 16'h0000;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy  = busy_reg;
    assign WE3   = we3_reg;
    assign A3    = a3_reg;
    assign WD3   = wd3_reg;
    assign pc_we = pc_we_reg;
    assign pc_wd = pc_wd_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table for the corner cases, then
// handshake-respecting random traffic checked against a behavioural model.
module tb_rf_write_arbiter;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req_valid;
    logic [11:0]  req_addr;
    logic [95:0]  req_data;
    logic [2:0]   req_ready;
    logic         rsv_valid;
    logic [3:0]   rsv_addr;
    logic [15:0]  busy;
    logic         WE3;
    logic [3:0]   A3;
    logic [31:0]  WD3;
    logic         pc_we;
    logic [31:0]  pc_wd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.N_REQ(3), .DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .busy(busy),
        .WE3(WE3), .A3(A3), .WD3(WD3),
        .pc_we(pc_we), .pc_wd(pc_wd)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  valid;
        logic [11:0] addr;
        logic [95:0] data;
        logic        rv;
        logic [3:0]  ra;
        logic [2:0]  e_ready;
        logic        e_we;
        logic [3:0]  e_a3;
        logic [31:0] e_wd3;
        logic        e_pcwe;
        logic [31:0] e_pcwd;
        logic [15:0] e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [2:0] v,
                       input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic rv, input logic [3:0] ra,
                       input logic [2:0] er, input logic ewe, input logic [3:0] ea,
                       input logic [31:0] ewd, input logic epc, input logic [31:0] epwd,
                       input logic [15:0] eb);
        vec_t t;
        t.rst = r; t.valid = v; t.addr = {a2, a1, a0}; t.data = {d2, d1, d0};
        t.rv = rv; t.ra = ra; t.e_ready = er; t.e_we = ewe; t.e_a3 = ea;
        t.e_wd3 = ewd; t.e_pcwe = epc; t.e_pcwd = epwd; t.e_busy = eb;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Behavioural model state
    int          m_ptr;
    bit          m_busy [16];
    bit          m_we, m_pcwe;
    logic [3:0]  m_a3;
    logic [31:0] m_wd3, m_pcwd;
    bit          pend [N];
    logic [3:0]  paddr [N];
    logic [31:0] pdata [N];

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0;

        //   r  v      a0 a1 a2  d0            d1            d2        rv ra  er     we a3 wd3           pc pcwd     busy
        add(1, 3'b111, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 0, 0, 0,            0, 0,       16'h0000);
        add(1, 3'b111, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 0, 0, 0,            0, 0,       16'h0000);
        add(0, 3'b000, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 0, 0, 0,            0, 0,       16'h0000);
        add(0, 3'b000, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 0, 0, 0,            0, 0,       16'h0000);
        add(0, 3'b010, 0, 5, 0, 0,            32'hDEADBEEF, 0,        0, 0, 3'b010, 0, 0, 0,            0, 0,       16'h0000);
        add(0, 3'b000, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 1, 5, 32'hDEADBEEF, 0, 0,       16'h0000);
        add(0, 3'b000, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 0, 0, 0,            0, 0,       16'h0000);
        add(1, 3'b000, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 0, 0, 0,            0, 0,       16'h0000);
        add(0, 3'b111, 1, 2, 3, 32'hA0,       32'hA1,       32'hA2,   0, 0, 3'b001, 0, 0, 0,            0, 0,       16'h0000);
        add(0, 3'b111, 1, 2, 3, 32'hA0,       32'hA1,       32'hA2,   0, 0, 3'b010, 1, 1, 32'hA0,       0, 0,       16'h0000);
        add(0, 3'b111, 1, 2, 3, 32'hA0,       32'hA1,       32'hA2,   0, 0, 3'b100, 1, 2, 32'hA1,       0, 0,       16'h0000);
        add(0, 3'b111, 1, 2, 3, 32'hA0,       32'hA1,       32'hA2,   0, 0, 3'b001, 1, 3, 32'hA2,       0, 0,       16'h0000);
        add(0, 3'b111, 1, 2, 3, 32'hA0,       32'hA1,       32'hA2,   0, 0, 3'b010, 1, 1, 32'hA0,       0, 0,       16'h0000);
        add(0, 3'b111, 1, 2, 3, 32'hA0,       32'hA1,       32'hA2,   0, 0, 3'b100, 1, 2, 32'hA1,       0, 0,       16'h0000);
        add(0, 3'b000, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 1, 3, 32'hA2,       0, 0,       16'h0000);
        add(0, 3'b000, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 0, 0, 0,            0, 0,       16'h0000);
        add(0, 3'b100, 0, 0, 15, 0,           0,            32'h100,  0, 0, 3'b100, 0, 0, 0,            0, 0,       16'h0000);
        add(0, 3'b000, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 0, 0, 0,            1, 32'h100, 16'h0000);
        add(0, 3'b000, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 0, 0, 0,            0, 0,       16'h0000);
        add(0, 3'b000, 0, 0, 0, 0,            0,            0,        1, 3, 3'b000, 0, 0, 0,            0, 0,       16'h0000);
        add(0, 3'b000, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 0, 0, 0,            0, 0,       16'h0008);
        add(0, 3'b001, 3, 0, 0, 32'h33,       0,            0,        1, 3, 3'b001, 0, 0, 0,            0, 0,       16'h0008);
        add(0, 3'b000, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 1, 3, 32'h33,       0, 0,       16'h0008);
        add(0, 3'b010, 0, 3, 0, 0,            32'h44,       0,        0, 0, 3'b010, 0, 0, 0,            0, 0,       16'h0008);
        add(0, 3'b000, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 1, 3, 32'h44,       0, 0,       16'h0000);
        add(0, 3'b100, 0, 0, 3, 0,            0,            32'h66,   1, 9, 3'b100, 0, 0, 0,            0, 0,       16'h0000);
        add(0, 3'b001, 4, 0, 0, 32'h55,       0,            0,        0, 0, 3'b001, 1, 3, 32'h66,       0, 0,       16'h0200);
        add(1, 3'b010, 0, 7, 0, 0,            32'h77,       0,        1, 7, 3'b000, 1, 4, 32'h55,       0, 0,       16'h0200);
        add(0, 3'b111, 7, 7, 7, 32'h81,       32'h82,       32'h83,   0, 0, 3'b001, 0, 0, 0,            0, 0,       16'h0000);
        add(0, 3'b000, 0, 0, 0, 0,            0,            0,        0, 0, 3'b000, 1, 7, 32'h81,       0, 0,       16'h0000);

        foreach (tbl[n]) begin
            @(posedge clk); #1;
            rst = tbl[n].rst; req_valid = tbl[n].valid; req_addr = tbl[n].addr;
            req_data = tbl[n].data; rsv_valid = tbl[n].rv; rsv_addr = tbl[n].ra;
            #1;
            chk($sformatf("tbl[%0d].ready", n), 32'(req_ready), 32'(tbl[n].e_ready));
            chk($sformatf("tbl[%0d].we3", n), 32'(WE3), 32'(tbl[n].e_we));
            chk($sformatf("tbl[%0d].pc_we", n), 32'(pc_we), 32'(tbl[n].e_pcwe));
            chk($sformatf("tbl[%0d].busy", n), 32'(busy), 32'(tbl[n].e_busy));
            if (tbl[n].e_we) begin
                chk($sformatf("tbl[%0d].a3", n), 32'(A3), 32'(tbl[n].e_a3));
                chk($sformatf("tbl[%0d].wd3", n), WD3, tbl[n].e_wd3);
            end
            if (tbl[n].e_pcwe) chk($sformatf("tbl[%0d].pc_wd", n), pc_wd, tbl[n].e_pcwd);
            $display("[TB] vec %0d rst=%b valid=%b ready=%b we3=%b a3=%h wd3=%h pc_we=%b busy=%h",
                     n, rst, req_valid, req_ready, WE3, A3, WD3, pc_we, busy);
        end

        // Randomised traffic against the behavioural model
        for (int j = 0; j < N; j++) begin
            pend[j] = 1'b0; paddr[j] = '0; pdata[j] = '0;
        end
        m_ptr = 0; m_we = 0; m_pcwe = 0; m_a3 = '0; m_wd3 = '0; m_pcwd = '0;
        for (int r = 0; r < 16; r++) m_busy[r] = 1'b0;

        for (int it = 0; it < 400; it++) begin
            int          g;
            logic [2:0]  exp_ready;
            logic [15:0] exp_busy;
            @(posedge clk); #1;
            if (it > 0) begin
                for (int r = 0; r < 16; r++) exp_busy[r] = m_busy[r];
                chk($sformatf("rnd[%0d].we3", it), 32'(WE3), 32'(m_we));
                chk($sformatf("rnd[%0d].a3", it), 32'(A3), 32'(m_a3));
                chk($sformatf("rnd[%0d].wd3", it), WD3, m_wd3);
                chk($sformatf("rnd[%0d].pc_we", it), 32'(pc_we), 32'(m_pcwe));
                chk($sformatf("rnd[%0d].pc_wd", it), pc_wd, m_pcwd);
                chk($sformatf("rnd[%0d].busy", it), 32'(busy), 32'(exp_busy));
            end
            rst = (it == 0) || ($urandom_range(0, 49) == 0);
            for (int j = 0; j < N; j++) begin
                if (!pend[j] && $urandom_range(0, 2) != 0) begin
                    pend[j]  = 1'b1;
                    paddr[j] = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 15));
                    pdata[j] = $urandom;
                end
                req_valid[j] = pend[j];
                req_addr[j*4 +: 4]   = paddr[j];
                req_data[j*32 +: 32] = pdata[j];
            end
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_addr  = 4'($urandom_range(0, 15));
            #1;
            g = -1;
            if (!rst) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (g < 0 && pend[i]) g = i;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk($sformatf("rnd[%0d].ready", it), 32'(req_ready), 32'(exp_ready));
            $display("[TB] rnd %0d rst=%b valid=%b ready=%b grant=%0d rsv=%b/%h busy=%h",
                     it, rst, req_valid, req_ready, g, rsv_valid, rsv_addr, busy);

            if (rst) begin
                m_ptr = 0; m_we = 0; m_pcwe = 0; m_a3 = '0; m_wd3 = '0; m_pcwd = '0;
                for (int r = 0; r < 16; r++) m_busy[r] = 1'b0;
            end else begin
                m_we = 0; m_pcwe = 0;
                if (g >= 0) begin
                    if (paddr[g] == 4'hF) begin
                        m_pcwe = 1; m_pcwd = pdata[g];
                    end else begin
                        m_we = 1; m_a3 = paddr[g]; m_wd3 = pdata[g];
                    end
                    m_busy[paddr[g]] = 1'b0;
                    pend[g] = 1'b0;
                    m_ptr = (g + 1) % N;
                end
                if (rsv_valid) m_busy[rsv_addr] = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (WE3/A3/WD3) among N_REQ writeback requesters: ALU, load unit and branch-link.
- Uses a round-robin valid/ready handshake and drives registered write strobes.
- Writes to R15 are diverted to a separate PC write port, because the register file does not store R15.
- Maintains a 16-bit busy scoreboard so the issue stage can stall on pending destinations.

Parameters:
N_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 4, register address width (16 architectural registers, index 15 = PC)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  requester i has a write pending
req_addr  in  N_REQ*ADDR_W  destination per requester, packed, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  N_REQ*DATA_W  write data per requester, packed likewise
req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
rsv_valid  in  1  issue stage reserves a destination this cycle
rsv_addr  in  ADDR_W  reserved destination
busy  out  16  scoreboard; bit r set = write to register r outstanding
WE3  out  1  register file write enable (registered)
A3  out  ADDR_W  register file write address (registered)
WD3  out  DATA_W  register file write data (registered)
pc_we  out  1  PC write strobe for R15 destinations (registered)
pc_wd  out  DATA_W  PC write data (registered)

Behaviour:
- Clock, reset:
  - Single clock domain.
  - All state updates on posedge clk.
  - rst is sampled synchronously and overrides every other input in that cycle.
- Reset values:
  - req_ready = 0
  - WE3 = 0, A3 = 0, WD3 = 0
  - pc_we = 0, pc_wd = 0
  - busy = 16'h0000
  - round-robin pointer ptr = 0
- Arbitration (combinational from req_valid and ptr):
  - Search indices ptr, ptr+1, ..., wrapping mod N_REQ.
  - The first i with req_valid[i] gets req_ready[i] = 1.
  - At most one ready bit is high; all bits are 0 if no valid is asserted.
  - req_ready never depends on req_addr or req_data.
- Pointer update:
  - On a transfer to requester g, ptr <= (g+1) mod N_REQ.
  - ptr holds when there is no transfer.
- Write issue, 1-cycle latency:
  - A transfer in cycle t drives the outputs during cycle t+1, for exactly one cycle.
  - If addr != 15: WE3 = 1, A3 = addr, WD3 = data, pc_we = 0.
  - If addr == 15: pc_we = 1, pc_wd = data, WE3 = 0.
  - With no transfer in cycle t: WE3 = 0 and pc_we = 0 in t+1.
  - A3, WD3 and pc_wd hold their last values.
- Throughput: one write per cycle sustained.
- Handshake: requesters hold valid, addr and data stable until ready; the arbiter relies on this.
- Scoreboard:
  - rsv_valid sets busy[rsv_addr] at the next edge.
  - A transfer with addr a clears busy[a] at the same edge the transfer is accepted.
  - Reserve and clear of the same register in the same cycle: set wins, so busy stays 1 (a newer write is outstanding).
  - Reserve and clear of different registers in the same cycle: both take effect.
  - Clearing a register that is not busy is harmless.
  - Reserving R15 sets busy[15]; a pc write clears it.
- Reset mid-operation:
  - Any transfer accepted in the rst cycle is discarded.
  - No WE3 or pc_we pulse follows.
  - busy and ptr are cleared.

Test Plan:
1. Reset and idle:
   - Stimulus: assert rst 2 cycles with req_valid=3'b111, then release with req_valid=0.
   - Response: during reset, req_ready=0, busy=0, WE3=0, pc_we=0; after release, no write strobes.
2. Single write latency:
   - Stimulus: req 1 valid, addr=4'h5, data=32'hDEADBEEF in cycle t.
   - Response: ready[1]=1 in t; in t+1, WE3=1, A3=5, WD3=32'hDEADBEEF; in t+2, WE3=0.
3. Round-robin fairness:
   - Stimulus: all 3 valid continuously for 6 cycles from reset.
   - Response: grant order 0,1,2,0,1,2; WE3=1 on each of the following 6 cycles.
4. R15 diversion:
   - Stimulus: req 2 writes addr=4'hF, data=32'h00000100.
   - Response: next cycle pc_we=1, pc_wd=32'h100, WE3=0.
5. Scoreboard collision:
   - Stimulus: rsv addr 3 in cycle t; in t+2, a transfer to addr 3 and rsv_valid with addr 3 in the same cycle.
   - Response: busy[3]=1 after t and remains 1 after t+2; a later transfer to 3 with no reserve clears it to 0.
6. Reset mid-transfer:
   - Stimulus: transfer to addr 7 accepted in a cycle with rst=1.
   - Response: no WE3 pulse next cycle, busy=0, ptr=0 (next simultaneous grant goes to requester 0).
